aes_cipher_iter: RTL and testbench
==================================

// Module: aes_cipher_iter
// PURPOSE
//  Iterative AES forward cipher; consumes the registered round-key array from the key
//  expansion stage and encrypts one 128-bit block, one round per clock.
//  valid/ready on input and output; one block in flight. Sits between the plaintext
//  source and the ciphertext sink.
// PARAMETERS
//  Nk  4     key length in 32-bit words (4/6/8 = AES-128/192/256)
//  Nr  Nk+6  number of rounds; rkey holds 4*(Nr+1) words
// PORTS
//  clk        in   1            clock; all logic on posedge
//  reset      in   1            synchronous, active-high reset
//  rkey       in   32 x 4(Nr+1) round-key words; word w = rkey[w]
//  in_valid   in   1            pt is valid
//  in_ready   out  1            block can be accepted (idle)
//  pt         in   128          plaintext; FIPS byte n at pt[8n+:8]
//  out_valid  out  1            ct holds a finished block
//  out_ready  in   1            sink accepts ct
//  ct         out  128          ciphertext; FIPS byte n at ct[8n+:8]
//  busy       out  1            block in flight (RUN or DONE)
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high.
//  - State layout: column c = state[32c+:32]; row r = byte [8r+:8] of the column
//    (same LSB-first word/byte order as rkey).
//  - FSM IDLE -> RUN -> DONE -> IDLE. Registers: state[127:0], round counter (4b).
//  - IDLE: in_ready=1. On in_valid&in_ready: state <= pt ^ {rkey[3],..,rkey[0]},
//    round <= 1, go RUN.
//  - RUN: each cycle apply round r = round: SubBytes (aes_pkg::SubWord per column),
//    ShiftRows (row r rotated left by r columns), MixColumns (GF(2^8), poly 0x11B),
//    AddRoundKey with rkey[4r..4r+3]. Round Nr omits MixColumns. round++.
//    After round Nr is applied, go DONE.
//  - DONE: out_valid=1, ct=state, held stable until out_valid&out_ready; then IDLE.
//    New input is accepted no earlier than the cycle after the out handshake.
//  - Latency: accept at edge 0; out_valid high from edge Nr (10/12/14 cycles).
//    Throughput: one block per Nr+2 cycles with out_ready=1.
//  - in_ready = (fsm==IDLE); busy = !in_ready; out_valid = (fsm==DONE); ct = state
//    at all times (don't-care to sink outside DONE).
//  - rkey must stay constant from accept through DONE handshake; upstream key load
//    is gated by !busy. A changed rkey mid-block gives an undefined ct but the FSM
//    still completes normally.
//  - in_valid while busy: ignored; pt not sampled.
//  - Reset (any state, including mid-RUN/DONE): fsm=IDLE, state=0, round=0;
//    out_valid=0, in_ready=1, busy=0, ct=0 in the cycle after reset is sampled.
//    The in-flight block is dropped.
//  - No combinational path from in_valid/out_ready to any output.
// TESTING
//  1 AES-128 FIPS-197 C.1: key bytes 00..0f, pt=128'hffeeddccbbaa99887766554433221100
//    -> ct=128'h5ac5b47080b7cdd830047b6ad8e0c469, out_valid 10 cycles after accept.
//  2 AES-192 C.2 (Nk=6): key 00..17, same pt -> ct bytes dda97ca4864cdfe06eaf70a0ec0d7191;
//    latency 12.
//  3 AES-256 C.3 (Nk=8): key 00..1f, same pt -> ct bytes 8ea2b7ca516745bfeafc49904b496089;
//    latency 14.
//  4 Backpressure: out_ready=0 for 5 cycles in DONE -> ct/out_valid stable, in_ready=0,
//    in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
//  5 Back-to-back: 4 random blocks, in_valid/out_ready held 1 -> each ct matches the
//    reference model; accepts spaced Nr+2 cycles apart.
//  6 Reset at round 5 -> next cycle out_valid=0, in_ready=1, ct=0; a fresh C.1
//    block then yields the correct ct.

Source files
------------

// File: rtl/aes_cipher_iter.sv
// Iterative AES forward cipher, one round per clock, one block in flight.
// State and round keys use LSB-first byte order: FIPS byte n at [8n+:8].
package aes_pkg;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[11'd2047 - {b, 3'b000} -: 8];
    endfunction

    function automatic logic [31:0] SubWord(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

module aes_cipher_iter
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  rkey [4*(Nr+1)],
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] pt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ct,
    output logic         busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]   fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [3:0]   round_q, round_d;

    logic [127:0] sub_s, shf_s, mix_s, rnd_s;
    logic         last;

    assign last = (round_q == 4'(Nr));

    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        logic [5:0] kidx;
        sub_s = '0;
        shf_s = '0;
        mix_s = '0;
        rnd_s = '0;
        for (int c = 0; c < 4; c++) begin
            sub_s[32*c +: 32] = SubWord(state_q[32*c +: 32]);
        end
        // Row r of column c takes row r from column c+r.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shf_s[32*c + 8*r +: 8] = sub_s[32*((c + r) % 4) + 8*r +: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = shf_s[32*c      +: 8];
            a1 = shf_s[32*c + 8  +: 8];
            a2 = shf_s[32*c + 16 +: 8];
            a3 = shf_s[32*c + 24 +: 8];
            mix_s[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mix_s[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mix_s[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mix_s[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        for (int c = 0; c < 4; c++) begin
            kidx = {round_q, 2'b00} + 6'(c);
            rnd_s[32*c +: 32] = (last ? shf_s[32*c +: 32] : mix_s[32*c +: 32])
                              ^ rkey[kidx];
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        round_d = round_q;
        unique case (fsm_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = pt ^ {rkey[3], rkey[2], rkey[1], rkey[0]};
                    round_d = 4'd1;
                    fsm_d   = S_RUN;
                end
            end
            S_RUN: begin
                state_d = rnd_s;
                round_d = round_q + 4'd1;
                if (last) fsm_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) fsm_d = S_IDLE;
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            round_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    assign in_ready  = (fsm_q == S_IDLE);
    assign busy      = !in_ready;
    assign out_valid = (fsm_q == S_DONE);
    assign ct        = state_q;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Bench for aes_cipher_iter: FIPS-197 KATs for three key sizes plus random
// blocks against a byte-matrix AES model, backpressure and mid-block reset.
module tb_aes_cipher_iter;

    localparam logic [127:0] PT = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] C1 = 128'h5ac5b47080b7cdd830047b6ad8e0c469;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [2:0]   in_valid, out_ready, in_ready, out_valid, busy;
    logic [127:0] pt [3];
    logic [127:0] ct4, ct6, ct8;
    logic [31:0]  rk4 [44];
    logic [31:0]  rk6 [52];
    logic [31:0]  rk8 [60];
    logic [31:0]  ks [3][60];
    logic [7:0]   kb [3][32];
    logic [7:0]   sbx [256];
    int n_chk = 0;
    int n_pass = 0;

    always_comb for (int i = 0; i < 44; i++) rk4[i] = ks[0][i];
    always_comb for (int i = 0; i < 52; i++) rk6[i] = ks[1][i];
    always_comb for (int i = 0; i < 60; i++) rk8[i] = ks[2][i];

    aes_cipher_iter #(.Nk(4)) u_d4 (
        .clk(clk), .reset(reset), .rkey(rk4),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .pt(pt[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .ct(ct4),
        .busy(busy[0])
    );
    aes_cipher_iter #(.Nk(6)) u_d6 (
        .clk(clk), .reset(reset), .rkey(rk6),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .pt(pt[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .ct(ct6),
        .busy(busy[1])
    );
    aes_cipher_iter #(.Nk(8)) u_d8 (
        .clk(clk), .reset(reset), .rkey(rk8),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .pt(pt[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .ct(ct8),
        .busy(busy[2])
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [127:0] ct_of(input int k);
        return (k == 0) ? ct4 : (k == 1) ? ct6 : ct8;
    endfunction

    function automatic logic [127:0] rev(input logic [127:0] x);
        logic [127:0] o;
        for (int n = 0; n < 16; n++) o[8*n +: 8] = x[8*(15-n) +: 8];
        return o;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic init_sbox();
        logic [7:0] inv, x, s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = inv ^ 8'h63;
            x = inv;
            for (int j = 0; j < 4; j++) begin
                x = {x[6:0], x[7]};
                s ^= x;
            end
            sbx[a] = s;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbx[w[31:24]], sbx[w[23:16]], sbx[w[15:8]], sbx[w[7:0]]};
    endfunction

    task automatic expand(input int k);
        int nk = 4 + 2*k;
        int nw = 4 * (nk + 7);
        logic [7:0] rc = 8'h01;
        logic [31:0] t;
        for (int i = 0; i < nk; i++)
            ks[k][i] = {kb[k][4*i+3], kb[k][4*i+2], kb[k][4*i+1], kb[k][4*i]};
        for (int i = nk; i < nw; i++) begin
            t = ks[k][i-1];
            if (i % nk == 0) begin
                t = subw({t[7:0], t[31:8]}) ^ {24'h0, rc};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            ks[k][i] = ks[k][i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] model(input int k, input logic [127:0] p);
        logic [7:0] s [4][4];
        logic [7:0] t [4][4];
        logic [7:0] a [4];
        logic [127:0] o;
        int nr = 10 + 2*k;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = p[8*(4*c+r) +: 8] ^ ks[k][c][8*r +: 8];
        for (int rd = 1; rd <= nr; rd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sbx[s[r][(c+r) % 4]];
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) a[r] = t[r][c];
                if (rd < nr) begin
                    s[0][c] = gmul(2, a[0]) ^ gmul(3, a[1]) ^ a[2] ^ a[3];
                    s[1][c] = a[0] ^ gmul(2, a[1]) ^ gmul(3, a[2]) ^ a[3];
                    s[2][c] = a[0] ^ a[1] ^ gmul(2, a[2]) ^ gmul(3, a[3]);
                    s[3][c] = gmul(3, a[0]) ^ a[1] ^ a[2] ^ gmul(2, a[3]);
                end else begin
                    for (int r = 0; r < 4; r++) s[r][c] = a[r];
                end
                for (int r = 0; r < 4; r++) s[r][c] ^= ks[k][4*rd+c][8*r +: 8];
            end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) o[8*(4*c+r) +: 8] = s[r][c];
        return o;
    endfunction

    // Starts and ends on a negedge with the instance idle.
    task automatic run_block(input int k, input logic [127:0] p,
                             input logic [127:0] exp, input string tag);
        int lat = 0;
        chk({tag, "_in_ready"}, 128'(in_ready[k]), 128'd1);
        pt[k] = p;
        in_valid[k] = 1'b1;
        out_ready[k] = 1'b0;
        @(negedge clk);
        in_valid[k] = 1'b0;
        while (!out_valid[k] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 128'(lat), 128'(10 + 2*k));
        chk({tag, "_ct"}, ct_of(k), exp);
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
        chk({tag, "_post_out_valid"}, 128'(out_valid[k]), 128'd0);
        chk({tag, "_post_in_ready"}, 128'(in_ready[k]), 128'd1);
    endtask

    initial begin
        logic [127:0] p, e, held;
        logic [127:0] bp [4];
        logic [127:0] be [4];
        int acc [4];
        int na, nd, cyc;

        reset = 1'b1;
        in_valid = '0;
        out_ready = '0;
        for (int k = 0; k < 3; k++) pt[k] = '0;
        init_sbox();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 32; i++) kb[k][i] = 8'(i);
            expand(k);
        end
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'd7);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_ct", ct4, 128'd0);
        reset = 1'b0;
        @(negedge clk);

        run_block(0, PT, C1, "c1");
        run_block(1, PT, rev(128'hdda97ca4864cdfe06eaf70a0ec0d7191), "c2");
        run_block(2, PT, rev(128'h8ea2b7ca516745bfeafc49904b496089), "c3");

        for (int i = 0; i < 16; i++) kb[0][i] = 8'($urandom);
        expand(0);
        p = {$urandom, $urandom, $urandom, $urandom};
        e = model(0, p);
        pt[0] = p;
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        cyc = 0;
        while (!out_valid[0] && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp_ct", ct4, e);
        held = ct4;
        for (int i = 0; i < 5; i++) begin
            in_valid[0] = (i % 2 == 0);
            pt[0] = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("bp_out_valid", 128'(out_valid[0]), 128'd1);
            chk("bp_in_ready", 128'(in_ready[0]), 128'd0);
            chk("bp_ct_stable", ct4, held);
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        chk("bp_idle_in_ready", 128'(in_ready[0]), 128'd1);
        chk("bp_idle_out_valid", 128'(out_valid[0]), 128'd0);
        @(negedge clk);
        chk("bp_no_accept", 128'(busy[0]), 128'd0);

        for (int i = 0; i < 4; i++) begin
            bp[i] = {$urandom, $urandom, $urandom, $urandom};
            be[i] = model(0, bp[i]);
        end
        na = 0;
        nd = 0;
        cyc = 0;
        out_ready[0] = 1'b1;
        while (nd < 4 && cyc < 200) begin
            if (out_valid[0]) begin
                chk("b2b_ct", ct4, be[nd]);
                nd++;
            end
            if (in_ready[0] && na < 4) begin
                pt[0] = bp[na];
                in_valid[0] = 1'b1;
                acc[na] = cyc;
                na++;
            end else if (na == 4) begin
                in_valid[0] = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b0;
        chk("b2b_done_count", 128'(nd), 128'd4);
        for (int i = 1; i < 4; i++)
            chk("b2b_spacing", 128'(acc[i] - acc[i-1]), 128'd12);
        @(negedge clk);

        for (int i = 0; i < 16; i++) kb[0][i] = 8'(i);
        expand(0);
        pt[0] = PT;
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy", 128'(busy[0]), 128'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_out_valid", 128'(out_valid[0]), 128'd0);
        chk("mid_rst_in_ready", 128'(in_ready[0]), 128'd1);
        chk("mid_rst_busy", 128'(busy[0]), 128'd0);
        chk("mid_rst_ct", ct4, 128'd0);
        run_block(0, PT, C1, "rst_c1");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
